fifo_wr_ptr_pkt: RTL



---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_ptr_sync.sv | 25 ++
 rtl/fifo_wr_ptr_pkt.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types and pointer encoding helpers for the packet-aware FIFO write side.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } wr_state_e;

  // Helpers work on a wide zero-extended vector so any pointer width up to
  // GRAY_MAX_W can use them; callers cast back to their own width.
  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Multi-flop synchroniser bringing the Gray read pointer into the write clock domain.
module fifo_ptr_sync #(
  parameter int WIDTH  = 10,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ptr_pkt.sv
// FIFO write-pointer manager with store-and-forward packet commit/drop and
// registered full/almost_full/fill flags computed from next-state pointers.
module fifo_wr_ptr_pkt import fifo_pkg::*; #(
  parameter int ADDR_WIDTH  = 9,
  parameter int SYNC_STAGES = 2,
  parameter int PACKET_MODE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_last,
  input  logic                  wr_drop,
  input  logic [ADDR_WIDTH:0]   af_level,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   w_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  output logic                  pkt_dropped,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PW-1:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};

  wr_state_e     state, nxt_state;
  logic [PW-1:0] wr_ptr_bin, cmt_ptr_bin, nxt_wr_ptr, nxt_cmt_ptr, ptr_inc;
  logic [PW-1:0] rd_gray_sync, rd_bin, nxt_fill;
  logic          accept, ovf_evt, drop_evt;
  logic          full_p1, af_p1, ovf_p1, pdrop_p1;
  logic [PW-1:0] fill_p1, gray_p1;

  fifo_ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rd_ptr_gray),
    .q     (rd_gray_sync)
  );

  assign rd_bin  = PW'(gray2bin(GRAY_MAX_W'(rd_gray_sync)));
  assign ptr_inc = wr_ptr_bin + PTR_ONE;
  assign accept  = wr_en && !full_p1 && (state != DROP);
  assign ovf_evt = wr_en && full_p1;

  always_comb begin
    nxt_wr_ptr  = wr_ptr_bin;
    nxt_cmt_ptr = cmt_ptr_bin;
    nxt_state   = state;
    drop_evt    = 1'b0;
    if (PACKET_MODE == 0) begin
      if (accept) nxt_wr_ptr = ptr_inc;
      nxt_cmt_ptr = nxt_wr_ptr;
    end else begin
      case (state)
        IDLE: begin
          // wr_ptr equals cmt_ptr here, so entering DROP needs no rewind.
          if (ovf_evt) begin
            if (!wr_last) begin
              nxt_state = DROP;
              drop_evt  = 1'b1;
            end
          end else if (accept && !wr_drop) begin
            nxt_wr_ptr = ptr_inc;
            if (wr_last) nxt_cmt_ptr = ptr_inc;
            else         nxt_state   = IN_PKT;
          end
        end
        IN_PKT: begin
          // A blocked write mid-packet loses a word, so the packet is rewound.
          if (wr_drop || ovf_evt) begin
            nxt_wr_ptr = cmt_ptr_bin;
            drop_evt   = 1'b1;
            nxt_state  = (wr_drop || wr_last) ? IDLE : DROP;
          end else if (accept) begin
            nxt_wr_ptr = ptr_inc;
            if (wr_last) begin
              nxt_cmt_ptr = ptr_inc;
              nxt_state   = IDLE;
            end
          end
        end
        DROP: begin
          if (wr_en && wr_last) nxt_state = IDLE;
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  assign nxt_fill = nxt_wr_ptr - rd_bin;

  // Stage 1: pointers, state and flags registered from next-state values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_bin  <= '0;
      cmt_ptr_bin <= '0;
      state       <= IDLE;
      full_p1     <= 1'b0;
      af_p1       <= 1'b0;
      ovf_p1      <= 1'b0;
      pdrop_p1    <= 1'b0;
      fill_p1     <= '0;
      gray_p1     <= '0;
    end else begin
      wr_ptr_bin  <= nxt_wr_ptr;
      cmt_ptr_bin <= nxt_cmt_ptr;
      state       <= nxt_state;
      full_p1     <= (nxt_wr_ptr[ADDR_WIDTH] != rd_bin[ADDR_WIDTH]) &&
                     (nxt_wr_ptr[ADDR_WIDTH-1:0] == rd_bin[ADDR_WIDTH-1:0]);
      af_p1       <= (DEPTH - nxt_fill) <= af_level;
      ovf_p1      <= ovf_evt;
      pdrop_p1    <= drop_evt;
      fill_p1     <= nxt_fill;
      gray_p1     <= PW'(bin2gray(GRAY_MAX_W'(nxt_cmt_ptr)));
    end
  end

  assign w_addr      = wr_ptr_bin[ADDR_WIDTH-1:0];
  assign w_ptr_gray  = gray_p1;
  assign full        = full_p1;
  assign almost_full = af_p1;
  assign overflow    = ovf_p1;
  assign pkt_dropped = pdrop_p1;
  assign fill_level  = fill_p1;

endmodule
